// File: rtl/digit_scan_ctrl_if.sv
// Purpose : bundles the scan controller's control inputs and display-side outputs.
// Latency : n/a (wiring only).
// Backpress: none; the display side consumes the outputs every cycle.
//
// Signals:
//   en           scan enable; low freezes the prescaler and digit counter
//   load         one-cycle strobe qualifying value_in
//   value_in     four hex nibbles, [3:0] is the rightmost digit
//   blank_lz     leading-zero blanking enable
//   anode_driver active digit index towards anode_mux
//   digit_out    nibble of the committed value for the active digit
//   digit_blank  active digit must be blanked
//   frame_tick   one-cycle pulse when the scan wraps from digit 3 to 0
//   load_ack     one-cycle pulse when a new value reaches the display
interface digit_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] value_in;
    logic        blank_lz;
    logic [1:0]  anode_driver;
    logic [3:0]  digit_out;
    logic        digit_blank;
    logic        frame_tick;
    logic        load_ack;

    // Driver side: supplies control and value, observes the scan.
    modport master (
        output en, load, value_in, blank_lz,
        input  anode_driver, digit_out, digit_blank, frame_tick, load_ack
    );

    // Scan controller side.
    modport slave (
        input  en, load, value_in, blank_lz,
        output anode_driver, digit_out, digit_blank, frame_tick, load_ack
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Purpose : 4-digit seven-segment refresh scan with frame-aligned double-buffered value commit.
// Latency : frame_tick/load_ack visible right after the boundary edge; digit_out/digit_blank combinational.
// Backpress: none; en=0 freezes the scan but loads are still captured into the pending buffer.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, released synchronously by clk
//   scan   digit_scan_ctrl_if.slave: en, load, value_in, blank_lz in;
//          anode_driver, digit_out, digit_blank, frame_tick, load_ack out
module digit_scan_ctrl #(
    parameter int PRESCALE   = 100000,
    parameter int PRESCALE_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_scan_ctrl_if.slave   scan
);

    localparam logic [PRESCALE_W-1:0] PRE_LAST   = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE    = PRESCALE_W'(1);
    localparam logic [1:0]            LAST_DIGIT = 2'd3;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [1:0]            digit_idx;
    logic [15:0]           disp_reg;
    logic [15:0]           pend_reg;
    logic                  pending;
    logic                  frame_tick_q;
    logic                  load_ack_q;

    logic                  tick;
    logic                  boundary;

    // The prescaler only advances while enabled, so a frozen scan resumes
    // from the same position inside the digit slot.
    assign tick     = scan.en && (pre_cnt == PRE_LAST);
    assign boundary = tick && (digit_idx == LAST_DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (scan.en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;   // 3 wraps to 0 naturally
            end
        end
    end

    // Double buffer: loads park in pend_reg and move to disp_reg only on a
    // frame boundary. A load landing exactly on the boundary bypasses the
    // pending buffer and supersedes whatever was parked there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg     <= 16'h0000;
            pend_reg     <= 16'h0000;
            pending      <= 1'b0;
            frame_tick_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            frame_tick_q <= boundary;
            load_ack_q   <= boundary && (pending || scan.load);
            if (boundary) begin
                if (scan.load) begin
                    disp_reg <= scan.value_in;
                end else if (pending) begin
                    disp_reg <= pend_reg;
                end
                pending <= 1'b0;
            end else if (scan.load) begin
                pend_reg <= scan.value_in;
                pending  <= 1'b1;
            end
        end
    end

    always_comb begin
        scan.digit_out = disp_reg[3:0];
        case (digit_idx)
            2'd0: scan.digit_out = disp_reg[3:0];
            2'd1: scan.digit_out = disp_reg[7:4];
            2'd2: scan.digit_out = disp_reg[11:8];
            2'd3: scan.digit_out = disp_reg[15:12];
            default: scan.digit_out = disp_reg[3:0];
        endcase
    end

    // A digit is a leading zero when it and every more significant nibble
    // are zero; the rightmost digit always shows so that 0 reads as "0".
    always_comb begin
        scan.digit_blank = 1'b0;
        if (scan.blank_lz) begin
            case (digit_idx)
                2'd1: scan.digit_blank = (disp_reg[15:4]  == 12'h000);
                2'd2: scan.digit_blank = (disp_reg[15:8]  == 8'h00);
                2'd3: scan.digit_blank = (disp_reg[15:12] == 4'h0);
                default: scan.digit_blank = 1'b0;
            endcase
        end
    end

    assign scan.anode_driver = digit_idx;
    assign scan.frame_tick   = frame_tick_q;
    assign scan.load_ack     = load_ack_q;

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Display refresh controller for the 4-digit seven-segment display, directly upstream of anode_mux. It owns the refresh prescaler and the 2-bit digit counter that drives anode_mux.anode_driver. It also selects the hex nibble for the active digit, which feeds the cathode decoder. New ALU results are double-buffered and committed only at frame boundaries, so a result never tears across digits.

Parameters:
PRESCALE, 100000, system clock cycles per digit slot (100 MHz gives a 1 kHz digit rate and 250 Hz frame rate); legal range 1..2^PRESCALE_W
PRESCALE_W, 17, width of the prescaler counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; when low, the scan freezes
load  input  1  one-cycle strobe: value_in is a new display value
value_in  input  16  four hex nibbles; [3:0] is the rightmost digit
blank_lz  input  1  leading-zero blanking enable
anode_driver  output  2  active digit index, connects to anode_mux.anode_driver
digit_out  output  4  nibble of the committed value for the active digit
digit_blank  output  1  active digit must be blanked (cathodes off)
frame_tick  output  1  one-cycle pulse when the scan wraps from 3 to 0
load_ack  output  1  one-cycle pulse when a pending value is committed to display

Behaviour:
- Reset (async assert, sync deassert by clk edge): prescaler=0, anode_driver=0, disp_reg=0, pend_reg=0, pending=0, frame_tick=0, load_ack=0. As a result, digit_out=0 and digit_blank=0.
- Prescaler, en=1:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted when count==PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- en=0:
  - prescaler and anode_driver hold.
  - frame_tick stays 0 and no commit occurs.
  - load is still accepted into pend_reg.
- On a tick: anode_driver <= anode_driver+1 mod 4 (sequence 0,1,2,3,0).
- Frame boundary = tick while anode_driver==3. On the same edge:
  - anode_driver <= 0.
  - frame_tick <= 1 for exactly one cycle.
  - If pending: disp_reg <= pend_reg, pending <= 0, load_ack <= 1 for one cycle.
- load with no boundary on the same edge:
  - pend_reg <= value_in, pending <= 1.
  - A further load before the boundary overwrites pend_reg: latest wins, and only one ack is issued.
- load coincident with a boundary:
  - value_in goes directly to disp_reg.
  - pending <= 0 and load_ack <= 1.
  - Any older pend_reg value is discarded.
- load_ack and frame_tick are registered. Latency from boundary-edge decision to pulse visible is 0 cycles after that edge; both are deasserted on the following edge.
- digit_out = disp_reg[4*anode_driver+3 : 4*anode_driver]. It is combinational from registers and valid in the same cycle as anode_driver.
- digit_blank:
  - Equals 0 when blank_lz=0.
  - When blank_lz=1, it is 1 iff anode_driver>0 and disp_reg nibbles anode_driver..3 are all zero.
  - Digit 0 is never blanked, so the value 0 displays as "0".
- Reset mid-frame: all state is cleared immediately and any pending load is lost, with no ack.

Test Plan:
1. PRESCALE=4, en=1, release rst_n -> anode_driver 0,1,2,3,0 with 4 cycles per step; frame_tick pulses for one cycle every 16 cycles, coinciding with anode_driver returning to 0.
2. load value_in=0x1234 while anode_driver=1 -> digit_out stays 0 until the boundary. load_ack pulses once with frame_tick. The next frame gives digit_out 4,3,2,1 for anode_driver 0,1,2,3.
3. load 0xAAAA, then load 0x0055 three cycles later in the same frame -> one load_ack only; the frame shows 5,5,0,0 and 0xA never appears.
4. blank_lz=1 -> value 0x0005 gives digit_blank 0,1,1,1; value 0x0000 gives 0,1,1,1 with digit_out 0 on digit 0; value 0x0100 gives 0,0,0,1. With blank_lz=0 all are 0.
5. en=0 for 10 cycles while anode_driver=2 -> anode_driver stays at 2 with no ticks. Then set en=1 -> the scan resumes from a held prescaler count, and any load issued while frozen commits at the next boundary.
6. load 0xBEEF on the exact boundary edge with 0x1111 pending -> disp_reg=0xBEEF, single load_ack, 0x1111 never shown. Asserting rst_n=0 mid-frame with pending set -> all outputs 0 immediately, and no ack after release.
